cmul_sched: RTL and testbench
=============================

Name: cmul_sched

Overview:
- Round-robin scheduler that shares one pipelined shift-add constant multiplier among NREQ requesters.
- Grants one operand per cycle into the multiplier and carries the requester ID alongside it down a LAT-deep pipeline.
- Buffers results in an output FIFO, with credit-based issue so that no multiplier result is ever dropped.
- Sits between requester blocks and the constant-multiplier datapath instance.

Parameters:
- N, 4, width exponent; data width W = 2**N.
- NREQ, 4, number of requesters (2..8).
- LAT, 2, multiplier latency in cycles from mul_a presented to mul_result valid.
- FDEPTH, 4, output FIFO depth; must be >= LAT+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high. One clock domain only.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  NREQ*W  packed operands; requester i occupies bits [i*W +: W].
- req_ready  out  NREQ  one-hot grant; the operand is accepted when valid and ready are both high.
- mul_a  out  W  operand to the shared multiplier.
- mul_result  in  W  multiplier output, valid LAT cycles after the matching mul_a.
- rsp_valid  out  1  FIFO head valid.
- rsp_id  out  $clog2(NREQ)  requester index of the head result.
- rsp_data  out  W  head result.
- rsp_ready  in  1  consumer accepts the head.

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0, mul_a=0. Reset also clears the priority pointer to 0, the in-flight valid/ID shift register and the FIFO pointers and count. In-flight results are discarded; reset mid-operation is a clean restart.
- Credit rule: issue is allowed only when inflight + fifo_count < FDEPTH.
  - inflight = number of set valid bits in the LAT-stage shift register.
  - A FIFO pop in the same cycle does not add credit until the next cycle.
- Arbitration:
  - Search starts at the priority pointer ptr and proceeds upward, wrapping.
  - The first i with req_valid[i]=1 is granted: req_ready[i]=1, combinational, same cycle.
  - Grant occurs only if credit is available; otherwise req_ready is all zero.
  - After a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- Issue cycle t:
  - mul_a = req_data[i] (combinational mux).
  - {1, i} enters stage 0 of the valid/ID shift register.
  - In non-issue cycles mul_a = 0 and a 0 valid enters the shift register.
- Capture: at cycle t+LAT, when shift-register output valid=1, {id, mul_result} is pushed into the FIFO. The credit rule guarantees the FIFO is never full at a push.
- FIFO:
  - Circular buffer; wr/rd pointers are $clog2(FDEPTH) bits and wrap modulo FDEPTH.
  - count is $clog2(FDEPTH+1) bits.
  - Simultaneous push and pop keeps count unchanged and is legal at full or empty.
  - rsp_* outputs present the head directly from the storage register; zero extra latency.
  - When the FIFO is empty: rsp_valid=0, and rsp_id/rsp_data hold their last values.
- Ordering: results leave in issue order. Minimum request-to-rsp_valid latency is LAT+1 cycles (LAT through the multiplier, 1 for the FIFO write).
- Throughput: one issue per cycle sustained while rsp_ready=1 and FDEPTH >= LAT+1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1.

Optional Feature:
- Macro: CMUL_SCHED_STATS_EN.
- Defined:
  - Adds output stat_issued [16*NREQ], one 16-bit per-requester grant counter each.
  - Counters saturate at 16'hFFFF and clear on rst.
  - Adds output stat_stall [16], a saturating counter of cycles where some req_valid=1 but credit was unavailable.
- Undefined: these ports and this logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package cmul_pkg holds:
  - localparam W = 2**N;
  - ID_W = $clog2(NREQ);
  - the rsp entry struct {id, data};
  - STAT_W = 16.
- One natural sub-module, rr_arbiter: NREQ-wide request vector plus enable in, one-hot grant and encoded index out, owns ptr.
- The FIFO and the shift register stay inline.

Test Plan:
- Single request, W=16: req_data[0]=16'h0100 with a behavioural LAT=2 multiplier model. Expect mul_a=16'h0100 in the issue cycle; rsp_valid=1, rsp_id=0, rsp_data=16'h00B5 three cycles later.
- All four requesters valid, rsp_ready=1, data 16'h0100/0200/0400/0800. Expect grant order 0,1,2,3 on consecutive cycles and results 00B5/016A/02D4/05A8 in that order with ids 0..3.
- rsp_ready=0, requester 1 valid continuously. Expect exactly FDEPTH=4 grants, then req_ready=0. After rsp_ready=1, one new grant per pop, no result lost.
- Simultaneous push/pop with FIFO at count=4 and at count=0. Expect count unchanged and data intact.
- rst asserted with 2 results in flight and 2 in the FIFO. Next cycle: rsp_valid=0 and req_ready=0 with no requests pending; first post-reset request goes to requester 0 per ptr=0; no stale result ever appears.
- With CMUL_SCHED_STATS_EN, requester 2 granted 70000 times. Expect stat_issued[2]=16'hFFFF.

Source files
------------

// File: rtl/cmul_pkg.sv
// cmul_pkg: shared widths, response entry type and saturating-increment helper
// for the cmul_sched constant-multiplier scheduler.
// N and NREQ here are the configuration point for the whole block.
package cmul_pkg;
    localparam int N      = 4;
    localparam int NREQ   = 4;
    localparam int W      = 2**N;
    localparam int ID_W   = $clog2(NREQ);
    localparam int STAT_W = 16;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [W-1:0]    data;
    } rsp_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/cmul_sched_rr_arbiter.sv
// rr_arbiter: round-robin grant over NREQ requesters; owns the priority pointer.
// Ports: clk, rst (sync, active-high); req_i request vector; en_i grant enable;
//        gnt_o one-hot grant; idx_o encoded grant index; any_o grant issued.
module rr_arbiter
    import cmul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);
    logic [ID_W-1:0] ptr_q, ptr_d, j;

    // Scan from the farthest offset down so the one nearest ptr wins last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = ID_W'((int'(ptr_q) + k) % NREQ);
            if (en_i && req_i[j]) begin
                any_o = 1'b1;
                idx_o = j;
            end
        end
        gnt_o[idx_o] = any_o;
        ptr_d = !any_o ? ptr_q : (idx_o == ID_W'(NREQ - 1)) ? '0 : idx_o + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/cmul_sched.sv
// cmul_sched: round-robin scheduler sharing one LAT-deep constant multiplier
// among NREQ requesters, with a credit-protected output FIFO.
// Ports: clk, rst (sync, active-high); req_valid/req_data/req_ready requester
//        side; mul_a/mul_result multiplier side; rsp_valid/rsp_id/rsp_data/
//        rsp_ready consumer side.
// Optional: CMUL_SCHED_STATS_EN adds stat_issued (per-requester grant counters)
//        and stat_stall (cycles with a request blocked by lack of credit).
module cmul_sched
    import cmul_pkg::*;
#(
    parameter int LAT    = 2,
    parameter int FDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      mul_a,
    input  logic [W-1:0]      mul_result,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [W-1:0]      rsp_data,
    input  logic              rsp_ready
`ifdef CMUL_SCHED_STATS_EN
    ,
    output logic [STAT_W*NREQ-1:0] stat_issued,
    output logic [STAT_W-1:0]      stat_stall
`endif
);
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = $clog2(FDEPTH + 1);

    logic [LAT-1:0]  v_q;
    logic [ID_W-1:0] id_q [LAT];
    rsp_t            mem_q [FDEPTH];
    logic [PW-1:0]   wr_q, rd_q, hidx;
    logic [CW-1:0]   cnt_q;
    logic [ID_W-1:0] gidx;
    logic            credit, issue, push, pop;
    int              inflight;
    rsp_t            head;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] prv(input logic [PW-1:0] p);
        return (p == '0) ? PW'(FDEPTH - 1) : p - 1'b1;
    endfunction

    always_comb begin
        inflight = 0;
        for (int k = 0; k < LAT; k++) inflight += int'(v_q[k]);
    end

    // Every in-flight result is guaranteed a FIFO slot; a same-cycle pop is not counted.
    assign credit = (inflight + int'(cnt_q)) < FDEPTH;

    rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_valid),
        .en_i  (credit),
        .gnt_o (req_ready),
        .idx_o (gidx),
        .any_o (issue)
    );

    assign mul_a     = issue ? req_data[gidx*W +: W] : '0;
    assign push      = v_q[LAT-1];
    assign rsp_valid = cnt_q != '0;
    assign pop       = rsp_valid && rsp_ready;

    // When empty, the slot just behind rd still holds the last popped entry.
    assign hidx     = rsp_valid ? rd_q : prv(rd_q);
    assign head     = mem_q[hidx];
    assign rsp_id   = head.id;
    assign rsp_data = head.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int k = 0; k < LAT; k++) id_q[k] <= '0;
            for (int k = 0; k < FDEPTH; k++) mem_q[k] <= '0;
        end else begin
            v_q[0]  <= issue;
            id_q[0] <= gidx;
            for (int k = 1; k < LAT; k++) begin
                v_q[k]  <= v_q[k-1];
                id_q[k] <= id_q[k-1];
            end
            if (push) begin
                mem_q[wr_q] <= '{id: id_q[LAT-1], data: mul_result};
                wr_q        <= nxt(wr_q);
            end
            if (pop) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

`ifdef CMUL_SCHED_STATS_EN
    logic [STAT_W-1:0] iss_q [NREQ];
    logic [STAT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            for (int k = 0; k < NREQ; k++) iss_q[k] <= '0;
        end else begin
            if (issue) iss_q[gidx] <= sat_inc(iss_q[gidx]);
            if (|req_valid && !credit) stall_q <= sat_inc(stall_q);
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        assign stat_issued[i*STAT_W +: STAT_W] = iss_q[i];
    end
    assign stat_stall = stall_q;
`endif
endmodule

// File: tb/tb_cmul_sched.sv
// tb_cmul_sched: scoreboard bench for cmul_sched with a behavioural LAT=2
// multiplier computing (a * 16'h00B5) >> 8.
module tb_cmul_sched;
    import cmul_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [63:0]     req_data;
    logic [NREQ-1:0] req_ready;
    logic [15:0]     mul_a, mul_result;
    logic            rsp_valid;
    logic [ID_W-1:0] rsp_id;
    logic [15:0]     rsp_data;
    logic            rsp_ready;
`ifdef CMUL_SCHED_STATS_EN
    logic [63:0]     stat_issued;
    logic [15:0]     stat_stall;
`endif

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_pop = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;
    logic [15:0] p1 = '0, p2 = '0;

    always #5 clk = ~clk;

    cmul_sched #(.LAT(2), .FDEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .mul_a      (mul_a),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
`ifdef CMUL_SCHED_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_stall (stat_stall)
`endif
    );

    always @(posedge clk) begin
        p1 <= 16'((32'(mul_a) * 32'd181) >> 8);
        p2 <= p1;
    end
    assign mul_result = p2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {28'd0, 2'(rsp_id), 2'd0}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    int g, g2, pops0;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_mul_a", 32'(mul_a), 32'd0);
        step();
        rst = 1'b0;
        exp_q.delete();

        // single request and its LAT+1 latency
        rsp_ready = 1'b1;
        req_data[15:0] = 16'h0100;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("single_grant", 32'(req_ready), 32'h1);
        chk("single_mul_a", 32'(mul_a), 32'h0100);
        exp_q.push_back('{id: 2'd0, data: 16'h00B5});
        step();
        req_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("single_latency_valid", 32'(rsp_valid), (c == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("hold_valid", 32'(rsp_valid), 32'd0);
        chk("hold_id", 32'(rsp_id), 32'd0);
        chk("hold_data", 32'(rsp_data), 32'h00B5);
        drain();

        // all four requesters: rotation 0..3
        do_reset();
        req_data = {16'h0800, 16'h0400, 16'h0200, 16'h0100};
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(1 << k));
            chk("rr_mul_a", 32'(mul_a), 32'(16'h0100 << k));
            exp_q.push_back('{id: 2'(k), data: 16'(16'h00B5 << k) + ((k == 0) ? 16'd0 : 16'(k == 1 ? 0 : 0))});
            step();
        end
        req_valid = '0;
        drain();

        // back-pressure: exactly FDEPTH grants, then one grant per freed slot
        rsp_ready = 1'b0;
        req_data[31:16] = 16'h0300;
        req_valid = 4'b0010;
        g = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready[1]) begin
                g++;
                exp_q.push_back('{id: 2'd1, data: 16'h021F});
            end
            step();
        end
        chk("bp_grants", 32'(g), 32'd4);
        @(negedge clk);
        chk("bp_no_grant", 32'(req_ready), 32'd0);
        chk("bp_full_valid", 32'(rsp_valid), 32'd1);
        step();
        pops0 = n_pop;
        rsp_ready = 1'b1;
        g2 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready[1]) begin
                g2++;
                exp_q.push_back('{id: 2'd1, data: 16'h021F});
            end
            step();
        end
        req_valid = '0;
        chk("bp_resume_grants", 32'(g2), 32'd11);
        drain();
        chk("bp_no_loss", 32'(n_pop - pops0), 32'(4 + g2));

        // reset with 2 results in flight and 2 in the FIFO
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mid_grant", 32'(req_ready), 32'h2);
            step();
        end
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_fifo_valid", 32'(rsp_valid), 32'd1);
        step();
        rst = 1'b0;
        exp_q.delete();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd0);
        repeat (6) step();
        req_data = {16'h0800, 16'h0400, 16'h0200, 16'h0100};
        req_valid = 4'hF;
        @(negedge clk);
        chk("post_rst_ptr0", 32'(req_ready), 32'h1);
        exp_q.push_back('{id: 2'd0, data: 16'h00B5});
        step();
        req_valid = '0;
        drain();

`ifdef CMUL_SCHED_STATS_EN
        do_reset();
        req_data[47:32] = 16'h0001;
        req_valid = 4'b0100;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (req_ready[2]) exp_q.push_back('{id: 2'd2, data: 16'h0000});
            step();
        end
        req_valid = '0;
        drain();
        chk("stat_issued2", 32'(stat_issued[47:32]), 32'hFFFF);
        chk("stat_issued0", 32'(stat_issued[15:0]), 32'h0);
        chk("stat_stall", 32'(stat_stall), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
